// File: rtl/seq_compare_pkg.sv
// Shared types for the sequential comparator.
// Mode and FSM encodings plus the mode-to-result helper.
package seq_compare_pkg;

    typedef enum logic [1:0] {
        CMP_SLT,
        CMP_SLTU,
        CMP_EQ,
        CMP_SLE
    } cmp_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Final result from the accumulated ordering flags.
    function automatic logic cmp_result(
        input cmp_op_t op,
        input logic    lt,
        input logic    dec
    );
        logic r;
        unique case (op)
            CMP_SLT, CMP_SLTU: r = lt;
            CMP_EQ:            r = ~dec;
            default:           r = lt | ~dec;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_compare_unit_chunk.sv
// Single-chunk comparator used once per BUSY cycle.
// flip_msb turns the unsigned compare into a signed one.
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] ca,
    input  logic [W-1:0] cb,
    input  logic         flip_msb,
    output logic         lt,
    output logic         eq
);

    logic [W-1:0] mask;
    logic [W-1:0] xa;
    logic [W-1:0] xb;

    // Bias the sign bit so an unsigned compare orders signed values.
    always_comb begin
        mask        = '0;
        mask[W-1]   = flip_msb;
        xa          = ca ^ mask;
        xb          = cb ^ mask;
        lt          = xa < xb;
        eq          = ca == cb;
    end

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle comparator, CHUNK bits per cycle, MSB chunk first.
// Define SEQ_COMPARE_MINMAX_EN to add min_out/max_out.
module seq_compare_unit
    import seq_compare_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef SEQ_COMPARE_MINMAX_EN
    output logic [N-1:0] min_out,
    output logic [N-1:0] max_out,
`endif
    output logic         out
);

    localparam int K  = N / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (N % CHUNK != 0) begin : g_bad_chunk
        $error("N must be a multiple of CHUNK");
    end

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    cmp_op_t        op_q, op_d;
    logic           lt_q, lt_d;
    logic           dec_q, dec_d;
    logic           out_q, out_d;
`ifdef SEQ_COMPARE_MINMAX_EN
    logic [N-1:0]   min_q, min_d;
    logic [N-1:0]   max_q, max_d;
`endif

    logic [N-1:0]     sh_a;
    logic [N-1:0]     sh_b;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             flip;
    logic             c_lt;
    logic             c_eq;

    // Select chunk cnt (chunk 0 is the MSB chunk) from the captured operands.
    always_comb begin
        sh_a = a_q >> (CHUNK * (K - 1 - int'(cnt_q)));
        sh_b = b_q >> (CHUNK * (K - 1 - int'(cnt_q)));
        ca   = sh_a[CHUNK-1:0];
        cb   = sh_b[CHUNK-1:0];
        flip = (cnt_q == '0) && (op_q != CMP_SLTU);
    end

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .ca       (ca),
        .cb       (cb),
        .flip_msb (flip),
        .lt       (c_lt),
        .eq       (c_eq)
    );

    // Next-state: capture, first-difference tracking, result latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        lt_d    = lt_q;
        dec_d   = dec_q;
        out_d   = out_q;
`ifdef SEQ_COMPARE_MINMAX_EN
        min_d   = min_q;
        max_d   = max_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                    a_d     = a;
                    b_d     = b;
                    op_d    = cmp_op_t'(op);
                    lt_d    = 1'b0;
                    dec_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (!dec_q && !c_eq) begin
                    dec_d = 1'b1;
                    lt_d  = c_lt;
                end
                if (cnt_q == CW'(K - 1)) begin
                    state_d = S_DONE;
                    out_d   = cmp_result(op_q, lt_d, dec_d);
`ifdef SEQ_COMPARE_MINMAX_EN
                    min_d   = lt_d ? a_q : b_q;
                    max_d   = lt_d ? b_q : a_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= CMP_SLT;
            lt_q    <= 1'b0;
            dec_q   <= 1'b0;
            out_q   <= 1'b0;
`ifdef SEQ_COMPARE_MINMAX_EN
            min_q   <= '0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            lt_q    <= lt_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
`ifdef SEQ_COMPARE_MINMAX_EN
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
`ifdef SEQ_COMPARE_MINMAX_EN
    assign min_out   = min_q;
    assign max_out   = max_q;
`endif

endmodule

// File: tb/tb_seq_compare_unit.sv
// Directed bench for seq_compare_unit at CHUNK=8, 32 and 1.
// Checks min_out/max_out when SEQ_COMPARE_MINMAX_EN is defined.
module tb_seq_compare_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        iv_x = 1'b0;
    logic        out_ready = 1'b0;
    logic        or_x = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;

    logic in_ready, out_valid, out;
    logic rdy32, ov32, o32;
    logic rdy1, ov1, o1;
`ifdef SEQ_COMPARE_MINMAX_EN
    logic [31:0] mn8, mx8, mn32, mx32, mn1, mx1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_compare_unit #(.N(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SEQ_COMPARE_MINMAX_EN
        .min_out(mn8), .max_out(mx8),
`endif
        .out(out)
    );

    seq_compare_unit #(.N(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv_x), .in_ready(rdy32),
        .a(a), .b(b), .op(op),
        .out_valid(ov32), .out_ready(or_x),
`ifdef SEQ_COMPARE_MINMAX_EN
        .min_out(mn32), .max_out(mx32),
`endif
        .out(o32)
    );

    seq_compare_unit #(.N(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv_x), .in_ready(rdy1),
        .a(a), .b(b), .op(op),
        .out_valid(ov1), .out_ready(or_x),
`ifdef SEQ_COMPARE_MINMAX_EN
        .min_out(mn1), .max_out(mx1),
`endif
        .out(o1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request to all three instances; checks latency and results.
    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic exp, input logic [31:0] emn,
                       input logic [31:0] emx);
        int   l8, l32, l1;
        logic bad_rdy;
        l8 = -1;
        l32 = -1;
        l1 = -1;
        bad_rdy = 1'b0;
        @(negedge clk);
        a = va;
        b = vb;
        op = o;
        in_valid = 1'b1;
        iv_x = 1'b1;
        chk({tag, ".rdy"}, {in_ready, rdy32, rdy1}, 3'b111);
        @(negedge clk);
        in_valid = 1'b0;
        iv_x = 1'b0;
        a = ~va;
        b = ~vb;
        op = ~o;
        chk({tag, ".ov0"}, {out_valid, ov32, ov1}, 3'b000);
        if (in_ready) bad_rdy = 1'b1;
        for (int j = 1; j <= 40 && (l8 < 0 || l32 < 0 || l1 < 0); j++) begin
            @(negedge clk);
            if (in_ready) bad_rdy = 1'b1;
            if (out_valid && l8 < 0) l8 = j;
            if (ov32 && l32 < 0) l32 = j;
            if (ov1 && l1 < 0) l1 = j;
        end
        chk({tag, ".lat8"}, l8, 4);
        chk({tag, ".lat32"}, l32, 1);
        chk({tag, ".lat1"}, l1, 32);
        chk({tag, ".busy_rdy"}, bad_rdy, 1'b0);
        chk({tag, ".out8"}, out, exp);
        chk({tag, ".out32"}, o32, exp);
        chk({tag, ".out1"}, o1, exp);
`ifdef SEQ_COMPARE_MINMAX_EN
        chk({tag, ".min8"}, mn8, emn);
        chk({tag, ".max8"}, mx8, emx);
        chk({tag, ".min1"}, mn1, emn);
        chk({tag, ".max32"}, mx32, emx);
`endif
        out_ready = 1'b1;
        or_x = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        or_x = 1'b0;
        chk({tag, ".hs"}, {out_valid, ov32, ov1, in_ready, rdy32, rdy1},
            6'b000111);
    endtask

    initial begin
        #12;
        chk("reset.flags", {in_ready, out_valid, out}, 3'b100);
`ifdef SEQ_COMPARE_MINMAX_EN
        chk("reset.minmax", {mn8, mx8}, 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run("t1_slt",  2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1,
            32'hFFFFFFFF, 32'h00000001);
        run("t2_sltu", 2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0,
            32'h00000001, 32'hFFFFFFFF);
        run("t2_slt",  2'b00, 32'h80000000, 32'h7FFFFFFF, 1'b1,
            32'h80000000, 32'h7FFFFFFF);
        run("t2_sltu2", 2'b01, 32'h80000000, 32'h7FFFFFFF, 1'b0,
            32'h7FFFFFFF, 32'h80000000);
        run("t3_eq",   2'b10, 32'h12345678, 32'h12345678, 1'b1,
            32'h12345678, 32'h12345678);
        run("t3_ne",   2'b10, 32'h12345679, 32'h12345678, 1'b0,
            32'h12345678, 32'h12345679);
        run("t3_sle",  2'b11, 32'h00000005, 32'h00000005, 1'b1,
            32'h00000005, 32'h00000005);

        // Backpressure on the CHUNK=8 instance.
        @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        op = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 10 && !out_valid; j++) @(negedge clk);
        chk("bp.done", out_valid, 1'b1);
        a = 32'd2;
        b = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.hold", {out_valid, out, in_ready}, 3'b110);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.idle", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.accept", {out_valid, in_ready}, 2'b00);
        repeat (3) @(negedge clk);
        chk("bp.lat_early", out_valid, 1'b0);
        @(negedge clk);
        chk("bp.new", {out_valid, out}, 2'b10);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the second BUSY cycle.
        @(negedge clk);
        a = 32'd3;
        b = 32'hFFFFFFFE;
        op = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        run("t5_rst", 2'b00, 32'd3, 32'hFFFFFFFE, 1'b0,
            32'hFFFFFFFE, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
